npc_predict: RTL and testbench

Parametrised next-PC unit for the pipelined MIPS core: holds the fetch PC register and predicts branch/jump redirects with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It also applies exception, `eret` and misprediction redirects by fixed priority, and raises a one-cycle flush on mispredict. It sits in the F stage and receives resolution from the stage that evaluates branches. Delay-slot semantics are preserved: entries are keyed by the delay-slot PC (branch PC + 4), so a hit redirects the fetch that follows the delay slot.

---
 rtl/npc_pkg.sv | 30 +++
 rtl/npc_btb_array.sv | 79 +++++++
 rtl/npc_predict.sv | 97 +++++++++
 tb/tb_npc_predict.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC predictor: reset/exception PCs, 2-bit counter
// encodings, per-entry BTB state and the counter saturation step.
package npc_pkg;

    localparam logic [31:0] NPC_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] NPC_EXC_VECTOR = 32'h0000_4180;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Tag and target widths depend on module parameters, so they live beside this struct.
    typedef struct packed {
        logic       vld;
        logic [1:0] ctr;
    } btb_meta_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_ST) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/npc_btb_array.sv
// Direct-mapped BTB: combinational lookup, update written on the clock edge (read-before-write).
// Only valid bits are reset; an update presented while reset is high is dropped.
module npc_btb_array
    import npc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BTB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:2] lk_pc,
    output logic              lk_pred_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_vld,
    input  logic [ADDR_W-1:2] upd_key,
    input  logic              upd_taken,
    input  logic              upd_uncond,
    input  logic [ADDR_W-1:0] upd_target
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    btb_meta_t         meta_q   [BTB_DEPTH];
    btb_meta_t         meta_d   [BTB_DEPTH];
    logic [TAG_W-1:0]  tag_q    [BTB_DEPTH];
    logic [TAG_W-1:0]  tag_d    [BTB_DEPTH];
    logic [ADDR_W-1:0] target_q [BTB_DEPTH];
    logic [ADDR_W-1:0] target_d [BTB_DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_en;
    logic             upd_hit;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_key[IDX_W+1:2];
    assign upd_tag = upd_key[ADDR_W-1:IDX_W+2];
    assign upd_en  = upd_vld && !reset;
    assign upd_hit = meta_q[upd_idx].vld && (tag_q[upd_idx] == upd_tag);

    assign lk_pred_taken = meta_q[lk_idx].vld && (tag_q[lk_idx] == lk_tag) && meta_q[lk_idx].ctr[1];
    assign lk_target     = target_q[lk_idx];

    always_comb begin
        meta_d   = meta_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd_en) begin
            if (upd_hit) begin
                meta_d[upd_idx].ctr = upd_uncond ? CTR_ST : ctr_step(meta_q[upd_idx].ctr, upd_taken);
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                meta_d[upd_idx].vld = 1'b1;
                meta_d[upd_idx].ctr = upd_uncond ? CTR_ST : CTR_WT;
                tag_d[upd_idx]      = upd_tag;
                target_d[upd_idx]   = upd_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                meta_q[i].vld <= 1'b0;
            end
        end else begin
            meta_q <= meta_d;
        end
    end

endmodule

// File: rtl/npc_predict.sv
// F-stage next-PC unit: fetch PC register, BTB prediction and priority redirects.
// Redirects land in pc_f one cycle later; flush is combinational; redirects override stall.
module npc_predict
    import npc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       BTB_DEPTH  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = NPC_RESET_PC,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = NPC_EXC_VECTOR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              exc_valid,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] epc,
    input  logic              res_valid,
    input  logic              res_uncond,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    input  logic              res_pred_taken,
    input  logic [ADDR_W-1:0] res_pred_target,
    output logic [ADDR_W-1:0] pc_f,
    output logic              pred_taken_f,
    output logic [ADDR_W-1:0] pred_target_f,
    output logic              flush,
    output logic [31:0]       mispredict_cnt
);

    logic [ADDR_W-1:0] pc_f_q, pc_f_d;
    logic [31:0]       mp_cnt_q, mp_cnt_d;
    logic [ADDR_W-1:0] btb_target;
    logic [ADDR_W-1:2] res_key;
    logic [ADDR_W-1:0] correct_pc;
    logic              mp;

    // Keyed by the delay-slot PC so a hit redirects the fetch after the delay slot.
    assign res_key = res_pc[ADDR_W-1:2] + 1'b1;

    npc_btb_array #(
        .ADDR_W    (ADDR_W),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .lk_pc         (pc_f_q[ADDR_W-1:2]),
        .lk_pred_taken (pred_taken_f),
        .lk_target     (btb_target),
        .upd_vld       (res_valid),
        .upd_key       (res_key),
        .upd_taken     (res_taken),
        .upd_uncond    (res_uncond),
        .upd_target    (res_target)
    );

    // The fetch stream follows the direction prediction; a not-taken hit falls through.
    assign pred_target_f = pred_taken_f ? btb_target : pc_f_q + ADDR_W'(4);

    assign mp = res_valid && ((res_taken != res_pred_taken) ||
                              (res_taken && (res_target != res_pred_target)));
    assign correct_pc = res_taken ? res_target : res_pc + ADDR_W'(8);
    assign flush      = mp && !exc_valid && !eret_valid && !reset;

    always_comb begin
        pc_f_d = pred_target_f;
        if (reset) begin
            pc_f_d = RESET_PC;
        end else if (exc_valid) begin
            pc_f_d = EXC_VECTOR;
        end else if (eret_valid) begin
            pc_f_d = epc;
        end else if (mp) begin
            pc_f_d = correct_pc;
        end else if (stall) begin
            pc_f_d = pc_f_q;
        end
    end

    always_comb begin
        mp_cnt_d = mp_cnt_q;
        if (reset) begin
            mp_cnt_d = '0;
        end else if (flush && mp_cnt_q != 32'hFFFF_FFFF) begin
            mp_cnt_d = mp_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        pc_f_q   <= pc_f_d;
        mp_cnt_q <= mp_cnt_d;
    end

    assign pc_f           = pc_f_q;
    assign mispredict_cnt = mp_cnt_q;

endmodule

// File: tb/tb_npc_predict.sv
// Directed bench for npc_predict with a 4-entry BTB so aliasing is easy to provoke.
module tb_npc_predict;

    logic        clk = 1'b0;
    logic        reset, stall, exc_valid, eret_valid;
    logic [31:0] epc;
    logic        res_valid, res_uncond, res_taken, res_pred_taken;
    logic [31:0] res_pc, res_target, res_pred_target;
    logic [31:0] pc_f, pred_target_f, mispredict_cnt;
    logic        pred_taken_f, flush;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    npc_predict #(
        .ADDR_W    (32),
        .BTB_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .exc_valid       (exc_valid),
        .eret_valid      (eret_valid),
        .epc             (epc),
        .res_valid       (res_valid),
        .res_uncond      (res_uncond),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .pc_f            (pc_f),
        .pred_taken_f    (pred_taken_f),
        .pred_target_f   (pred_target_f),
        .flush           (flush),
        .mispredict_cnt  (mispredict_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        reset           = 1'b0;
        stall           = 1'b0;
        exc_valid       = 1'b0;
        eret_valid      = 1'b0;
        epc             = '0;
        res_valid       = 1'b0;
        res_uncond      = 1'b0;
        res_pc          = '0;
        res_taken       = 1'b0;
        res_target      = '0;
        res_pred_taken  = 1'b0;
        res_pred_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt, input logic unc);
        res_valid       = 1'b1;
        res_pc          = pc;
        res_taken       = tk;
        res_target      = tgt;
        res_pred_taken  = ptk;
        res_pred_target = ptgt;
        res_uncond      = unc;
        #1;
    endtask

    task automatic eret_to(input logic [31:0] a);
        eret_valid = 1'b1;
        epc        = a;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        clr();
        // Reset with a pending resolution: no flush and no BTB write (key 0x300C).
        reset = 1'b1;
        resolve(32'h3008, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0);
        check_eq("rst_flush", 32'(flush), 32'h0);
        tick();
        check_eq("rst_pc", pc_f, 32'h3000);
        check_eq("rst_pred", 32'(pred_taken_f), 32'h0);
        check_eq("rst_cnt", mispredict_cnt, 32'h0);
        tick();
        check_eq("seq_pc1", pc_f, 32'h3004);
        check_eq("seq_pred1", 32'(pred_taken_f), 32'h0);
        tick();
        check_eq("seq_pc2", pc_f, 32'h3008);
        check_eq("seq_pred2", 32'(pred_taken_f), 32'h0);
        tick();
        check_eq("seq_pc3", pc_f, 32'h300C);
        check_eq("seq_pred3_nowrite", 32'(pred_taken_f), 32'h0);

        // Allocate at key 0x3014 (ctr 10) and predict it.
        resolve(32'h3010, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b0);
        check_eq("alloc_flush", 32'(flush), 32'h1);
        tick();
        check_eq("alloc_pc", pc_f, 32'h3040);
        check_eq("alloc_cnt", mispredict_cnt, 32'd1);
        eret_to(32'h3014);
        check_eq("hit_pc", pc_f, 32'h3014);
        check_eq("hit_pred", 32'(pred_taken_f), 32'h1);
        check_eq("hit_tgt", pred_target_f, 32'h3040);
        tick();
        check_eq("hit_next_pc", pc_f, 32'h3040);

        // Hysteresis: 10 -> 01 on not-taken.
        resolve(32'h3010, 1'b0, 32'h3040, 1'b1, 32'h3040, 1'b0);
        check_eq("nt_flush", 32'(flush), 32'h1);
        tick();
        check_eq("nt_pc", pc_f, 32'h3018);
        eret_to(32'h3014);
        check_eq("wnt_pred", 32'(pred_taken_f), 32'h0);
        // Two takens: 01 -> 10 -> 11.
        resolve(32'h3010, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b0);
        check_eq("t1_flush", 32'(flush), 32'h1);
        tick();
        check_eq("t1_pc", pc_f, 32'h3040);
        check_eq("t1_cnt", mispredict_cnt, 32'd3);
        resolve(32'h3010, 1'b1, 32'h3040, 1'b1, 32'h3040, 1'b0);
        check_eq("t2_flush", 32'(flush), 32'h0);
        tick();
        check_eq("t2_pc", pc_f, 32'h3044);
        // One not-taken from 11 leaves 10, still predicting taken.
        resolve(32'h3010, 1'b0, 32'h3040, 1'b1, 32'h3040, 1'b0);
        check_eq("st_nt_flush", 32'(flush), 32'h1);
        tick();
        check_eq("st_nt_pc", pc_f, 32'h3018);
        eret_to(32'h3014);
        check_eq("st_hyst_pred", 32'(pred_taken_f), 32'h1);
        check_eq("st_hyst_cnt", mispredict_cnt, 32'd4);

        // Priority: exception beats eret, mispredict and stall; BTB still updates (key 0x3108).
        exc_valid  = 1'b1;
        eret_valid = 1'b1;
        epc        = 32'h5000;
        stall      = 1'b1;
        resolve(32'h3104, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b0);
        check_eq("pri_exc_flush", 32'(flush), 32'h0);
        tick();
        check_eq("pri_exc_pc", pc_f, 32'h4180);
        eret_valid = 1'b1;
        epc        = 32'h5000;
        stall      = 1'b1;
        resolve(32'h3104, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b0);
        check_eq("pri_eret_flush", 32'(flush), 32'h0);
        tick();
        check_eq("pri_eret_pc", pc_f, 32'h5000);
        check_eq("pri_cnt", mispredict_cnt, 32'd4);
        stall = 1'b1;
        tick();
        check_eq("stall_pc1", pc_f, 32'h5000);
        stall = 1'b1;
        tick();
        check_eq("stall_pc2", pc_f, 32'h5000);
        eret_to(32'h3108);
        check_eq("exc_upd_pred", 32'(pred_taken_f), 32'h1);
        check_eq("exc_upd_tgt", pred_target_f, 32'h3200);

        // Same-cycle update at the fetched index returns the old entry.
        eret_to(32'h3014);
        resolve(32'h3010, 1'b1, 32'h3080, 1'b1, 32'h3040, 1'b0);
        check_eq("rbw_pred", 32'(pred_taken_f), 32'h1);
        check_eq("rbw_tgt", pred_target_f, 32'h3040);
        check_eq("rbw_flush", 32'(flush), 32'h1);
        tick();
        check_eq("rbw_pc", pc_f, 32'h3080);
        eret_to(32'h3014);
        check_eq("rbw_new_tgt", pred_target_f, 32'h3080);
        // Key 0x3024 aliases index 1 with a new tag and replaces the entry.
        resolve(32'h3020, 1'b1, 32'h3300, 1'b0, 32'h0, 1'b1);
        check_eq("alias_flush", 32'(flush), 32'h1);
        tick();
        check_eq("alias_pc", pc_f, 32'h3300);
        check_eq("alias_cnt", mispredict_cnt, 32'd6);
        eret_to(32'h3014);
        check_eq("alias_old_pred", 32'(pred_taken_f), 32'h0);
        check_eq("alias_old_tgt", pred_target_f, 32'h3018);
        eret_to(32'h3024);
        check_eq("alias_new_pred", 32'(pred_taken_f), 32'h1);
        check_eq("alias_new_tgt", pred_target_f, 32'h3300);

        // Wrap-around of pc + 4 and res_pc + 8.
        eret_to(32'hFFFF_FFFC);
        check_eq("wrap_pred", 32'(pred_taken_f), 32'h0);
        check_eq("wrap_tgt", pred_target_f, 32'h0);
        tick();
        check_eq("wrap_pc", pc_f, 32'h0);
        resolve(32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b0);
        check_eq("wrap8_flush", 32'(flush), 32'h1);
        tick();
        check_eq("wrap8_pc", pc_f, 32'h0);
        check_eq("final_cnt", mispredict_cnt, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
